uart_rx_edge_bit_sampler: RTL

//  - Timing and sampling front end of the UART receiver. Sits directly upstream of the RX control FSM.
//  - Counts oversampling clock edges within each bit period and counts bits within a frame.
//  - Majority-votes three mid-bit samples of the serial line into one sampled bit.
//  - Drives edge_count, bit_count and sampled_bit to the FSM. Takes its enables back from the FSM.

---
 rtl/uart_rx_edge_bit_sampler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing front end: edge/bit counters plus 3-point majority sampler.
// Optional macro RX_SYNC_EN adds a 2-flop synchronizer on rx (reset to 1).
module uart_rx_edge_bit_sampler #(
    parameter int EDGE_W  = 16,
    parameter int PRESC_W = 8,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               cnt_en,
    input  logic               smp_en,
    output logic               rx_line,
    output logic [EDGE_W-1:0]  edge_count,
    output logic [BIT_W-1:0]   bit_count,
    output logic               sampled_bit,
    output logic               sample_valid,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                cnt_en_q;
    logic                cnt_rise;
    logic [PRESC_W-1:0]  presc_q;
    logic [EDGE_W-1:0]   last_edge;
    logic [EDGE_W-1:0]   mid;
    logic [EDGE_W-1:0]   edge_d;
    logic [BIT_W-1:0]    bit_d;
    logic                s0, s1;
    logic [1:0]          vld_pipe;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx};
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = rx;
`endif

    // Resetting the edge detector high means an enable already high when reset
    // releases is not a rise; counting waits for a fresh 0->1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_en_q <= 1'b1;
        else      cnt_en_q <= cnt_en;
    end

    assign cnt_rise = cnt_en & ~cnt_en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          presc_q <= '0;
        else if (cnt_rise) presc_q <= prescale;
    end

    assign last_edge = EDGE_W'(presc_q) - EDGE_W'(1);
    assign mid       = EDGE_W'(presc_q >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // The RUN/ERR decision uses the live prescale, which is the value presc_q latches on this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cnt_rise) state_d = (prescale < PRESC_W'(4)) ? ERR : RUN;
            end
            RUN, ERR: begin
                if (!cnt_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_err = (state_q == ERR);

    always_comb begin
        edge_d = edge_count;
        bit_d  = bit_count;
        if (state_q != RUN || !cnt_en) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (edge_count == last_edge) begin
            edge_d = '0;
            if (bit_count != {BIT_W{1'b1}}) bit_d = bit_count + BIT_W'(1);
        end else begin
            edge_d = edge_count + EDGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else begin
            edge_count <= edge_d;
            bit_count  <= bit_d;
        end
    end

    // vld_pipe tracks which of s0/s1 were captured with sampling enabled;
    // any gap in smp_en discards the partial set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            vld_pipe     <= '0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state_q != RUN || !smp_en) begin
                vld_pipe <= '0;
            end else if (edge_count == mid - EDGE_W'(1)) begin
                s0       <= rx_line;
                vld_pipe <= 2'b01;
            end else if (edge_count == mid) begin
                s1       <= rx_line;
                vld_pipe <= {vld_pipe[0], 1'b0};
            end else if (edge_count == mid + EDGE_W'(1)) begin
                vld_pipe <= '0;
                if (vld_pipe[1]) begin
                    sampled_bit  <= (s0 & s1) | (s0 & rx_line) | (s1 & rx_line);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule
